// File: rtl/multicycle_mem_responder.sv
// Unified instruction/data word RAM behind MemRead/MemWrite; optional MMIO window via MEM_MMIO_EN.
// Latency: MemReady pulses WAIT_CYCLES+1 cycles after the accepting edge; one request in flight.
// Backpressure: none; strobes are ignored while Busy, and a strobe still high after RESP re-requests.

module multicycle_mem_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemError,
    output logic        Busy
`ifdef MEM_MMIO_EN
    ,
    output logic [7:0]  LedOut
`endif
);

`ifdef MEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {TGT_RAM, TGT_LED, TGT_CNT} tgt_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        logic                  write;
        logic                  err;
        tgt_t                  tgt;
    } req_t;

    state_t state, next_state;
    req_t   req, req_d;
    logic [3:0]  wait_cnt;
    logic        accept;
    logic        hi_nz, hit_led, hit_cnt;
    logic        commit, ram_we;
    logic [31:0] rd_mux;

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

`ifdef MEM_MMIO_EN
    logic [7:0]  led;
    logic [31:0] cyc_cnt;
`endif

    // Request classification happens once, at acceptance, so RESP only replays the latched verdict.
    always_comb begin
        hi_nz       = |Address[31:ADDR_WIDTH+2];
        hit_led     = MMIO_EN && (Address == MMIO_BASE);
        hit_cnt     = MMIO_EN && (Address == MMIO_BASE + 32'd4);
        req_d       = '0;
        req_d.addr  = Address[ADDR_WIDTH+1:2];
        req_d.wdata = WriteData;
        req_d.write = MemWrite;
        req_d.tgt   = hit_led ? TGT_LED : (hit_cnt ? TGT_CNT : TGT_RAM);
        req_d.err   = (MemRead && MemWrite)
                    || (Address[1:0] != 2'b00)
                    || (hi_nz && !hit_led && !hit_cnt)
                    || (hit_cnt && MemWrite);
    end

    always_comb begin
        rd_mux = mem[req.addr];
`ifdef MEM_MMIO_EN
        case (req.tgt)
            TGT_LED: rd_mux = {24'h0, led};
            TGT_CNT: rd_mux = cyc_cnt;
            default: rd_mux = mem[req.addr];
        endcase
`endif
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        MemReady   = 1'b0;
        MemError   = 1'b0;
        Busy       = 1'b0;
        ReadData   = '0;
        case (state)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    accept     = 1'b1;
                    next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                Busy = 1'b1;
                if (wait_cnt <= 4'd1) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                Busy       = 1'b1;
                MemReady   = 1'b1;
                MemError   = req.err;
                next_state = S_IDLE;
                if (!req.err && !req.write) begin
                    ReadData = rd_mux;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign commit = (state == S_RESP) && req.write && !req.err;
    assign ram_we = commit && (req.tgt == TGT_RAM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            req      <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                req      <= req_d;
                wait_cnt <= WAIT_LD;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // RAM has no reset; a reset coinciding with the RESP edge still suppresses the store.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            mem[req.addr] <= req.wdata;
        end
    end

`ifdef MEM_MMIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            led     <= '0;
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (commit && (req.tgt == TGT_LED)) begin
                led <= req.wdata[7:0];
            end
        end
    end

    assign LedOut = led;
`endif

endmodule
